data_memory_sequencer: RTL

Multi-cycle controller for the MEM stage of the pipelined RISC-V core. It sequences every load and store onto a request/acknowledge data-memory port and stalls the pipeline until the access completes. It aligns store data and byte enables, and extracts and sign-extends load data. It drives `result_src` and `memory_result` into the write-back result mux, where `result_src` = 1 selects the ALU result and 0 selects memory.

---
 rtl/mem_pkg.sv | 22 ++
 rtl/data_memory_sequencer_if.sv | 20 ++
 rtl/load_formatter.sv | 29 ++
 rtl/data_memory_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data memory sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Loads and stores share encodings; only the decoding context differs.
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int TIMEOUT_CYCLES_DEFAULT = 16;

endpackage

// File: rtl/data_memory_sequencer_if.sv
// Request/acknowledge data-memory port between the sequencer and memory.
interface data_memory_sequencer_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/load_formatter.sv
// Combinational lane select and sign/zero extension of a memory read word.
module load_formatter
  import mem_pkg::*;
(
  input  logic [31:0] dmem_rdata,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  output logic [31:0] load_data
);

  logic [3:0][7:0] lanes;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign lanes    = dmem_rdata;
  assign byte_sel = lanes[addr];
  assign half_sel = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (funct3)
      LB:      load_data = {{24{byte_sel[7]}}, byte_sel};
      LH:      load_data = {{16{half_sel[15]}}, half_sel};
      LBU:     load_data = {24'b0, byte_sel};
      LHU:     load_data = {16'b0, half_sel};
      default: load_data = dmem_rdata;
    endcase
  end

endmodule

// File: rtl/data_memory_sequencer.sv
// MEM-stage load/store sequencer: issues one request per access and stalls until ack.
// Optional access timeout is compiled in with `define MEM_TIMEOUT_EN.
module data_memory_sequencer
  import mem_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
`endif
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           mem_read,
  input  logic                           mem_write,
  input  logic [2:0]                     funct3,
  input  logic [31:0]                    addr,
  input  logic [31:0]                    store_data,
  data_memory_sequencer_if.master        dmem,
  output logic                           stall,
  output logic                           result_src,
  output logic [31:0]                    memory_result,
  output logic                           misaligned,
  output logic                           fault
);

  state_t      state;
  logic [2:0]  f3_q;
  logic [1:0]  lo_q;
  logic        is_load_q;
  logic        access, is_byte, is_half, aligned, accept;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] load_data;
  logic        timeout_hit;

  // Access size depends on direction: funct3 100/101 are byte/half only for loads.
  assign access  = mem_read | mem_write;
  assign is_byte = (funct3 == LB)  | (mem_read & (funct3 == LBU));
  assign is_half = (funct3 == LH)  | (mem_read & (funct3 == LHU));
  assign aligned = is_byte | (is_half ? ~addr[0] : (addr[1:0] == 2'b00));
  assign accept  = (state == IDLE) & access & aligned;

  always_comb begin
    be_n    = 4'b1111;
    wdata_n = store_data;
    if (!mem_read) begin
      case (funct3)
        SB: begin
          be_n    = 4'b0001 << addr[1:0];
          wdata_n = {4{store_data[7:0]}};
        end
        SH: begin
          be_n    = 4'b0011 << {addr[1], 1'b0};
          wdata_n = {2{store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  load_formatter u_fmt (
    .dmem_rdata (dmem.dmem_rdata),
    .funct3     (f3_q),
    .addr       (lo_q),
    .load_data  (load_data)
  );

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] to_cnt;
  logic          timed_out;

  // Counts BUSY cycles that have already passed without ack.
  assign timeout_hit = (state == BUSY) & ~dmem.dmem_ack &
                       (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (state == IDLE) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (state == BUSY && !dmem.dmem_ack) begin
      to_cnt <= to_cnt + CW'(1);
      if (timeout_hit) timed_out <= 1'b1;
    end
  end

  assign fault = (state == DONE) & timed_out;
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_be    <= '0;
      dmem.dmem_wdata <= '0;
      memory_result   <= '0;
      f3_q            <= '0;
      lo_q            <= '0;
      is_load_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state           <= BUSY;
          dmem.dmem_req   <= 1'b1;
          dmem.dmem_we    <= mem_write & ~mem_read;
          dmem.dmem_addr  <= {addr[31:2], 2'b00};
          dmem.dmem_be    <= be_n;
          dmem.dmem_wdata <= wdata_n;
          f3_q            <= funct3;
          lo_q            <= addr[1:0];
          is_load_q       <= mem_read;
        end
        BUSY: if (dmem.dmem_ack) begin
          state         <= DONE;
          dmem.dmem_req <= 1'b0;
          memory_result <= load_data;
        end else if (timeout_hit) begin
          state         <= DONE;
          dmem.dmem_req <= 1'b0;
          memory_result <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so reset forces the quiescent values even with a request pending.
  assign stall      = rst_n & (accept | (state == BUSY));
  assign misaligned = rst_n & (state == IDLE) & access & ~aligned;
  assign result_src = ~((state == DONE) & is_load_q);

endmodule
